pixel_scan_gen: RTL and testbench
=================================

PIXEL_SCAN_GEN -- requirements
Module: pixel_scan_gen

Interface
REQ-001 Parameter: W, 8, width of coordinate and dimension buses.
REQ-002 Parameter: BW, 3, width of border input.
REQ-003 Ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-004 Ports: start  in  1  one-cycle request to begin a frame scan.
REQ-005 Ports: abort  in  1  terminate the current scan.
REQ-006 Ports: max_x, max_y  in  W  image width and height in pixels.
REQ-007 Ports: border  in  BW  excluded margin on every edge, e.g. 3 for FAST radius.
REQ-008 Ports: serp  in  1  scan order: 0 = raster, 1 = serpentine.
REQ-009 Ports: pos_valid  out  1  curr_x/curr_y hold a valid position.
REQ-010 Ports: pos_ready  in  1  consumer accepts the position.
REQ-011 Ports: curr_x, curr_y  out  W  current position.
REQ-012 Ports: dir  out  1  current row direction: 0 = increasing x, 1 = decreasing x.
REQ-013 Ports: row_first, row_last  out  1  curr_x is the first/last position of its row.
REQ-014 Ports: frame_last  out  1  the final position of the frame.
REQ-015 Ports: busy  out  1 and done  out  1 (one-cycle pulse) and err  out  1 (sticky until next start).

Function
REQ-016 States: IDLE, SCAN, DONE; DONE lasts one cycle and returns to IDLE.
REQ-017 start in IDLE latches max_x, max_y, border, serp; later changes to these inputs during the scan are ignored.
REQ-018 start in SCAN or DONE is ignored.
REQ-019 Active region: x in [border, max_x-1-border]; y in [border, max_y-1-border]. Bounds are computed at W+1 bits, so there is no wrap.
REQ-020 Empty region (max_x <= 2*border or max_y <= 2*border): IDLE goes to DONE; err=1; pos_valid never asserts.
REQ-021 Non-empty region: the cycle after start, state = SCAN, pos_valid=1, curr=(border,border), dir=0.
REQ-022 Handshake: a position advances only on pos_valid && pos_ready. While stalled, curr_x, curr_y, dir and all flags hold stable.
REQ-023 pos_valid stays 1 throughout SCAN. Consecutive accepts yield one position per cycle, with no bubbles, including across row changes.
REQ-024 Raster order: x increments. At row_last, x returns to border, y increments, dir stays 0.
REQ-025 Serpentine order: at row_last, y increments, dir toggles, and x holds its value. The next row then steps in the new direction.
REQ-026 row_first = (curr_x == start edge for dir); row_last = (curr_x == end edge for dir). When the region is one column wide, both flags assert.
REQ-027 frame_last = row_last && (curr_y == y upper bound).
REQ-028 Accepting at frame_last moves the state to DONE: pos_valid=0 the next cycle, done=1 for one cycle.
REQ-029 busy = 1 in SCAN, else 0.
REQ-030 abort in SCAN: next cycle state = IDLE, pos_valid=0, no done pulse. abort has priority over a simultaneous accept.
REQ-031 In IDLE and DONE, curr_x and curr_y hold their last value. They are cleared to 0 only by reset.
REQ-032 Every position in the active region is emitted exactly once per frame.

Reset
REQ-033 rst asserted at any time, including mid-scan, forces state = IDLE immediately.
REQ-034 Reset values: pos_valid=0, curr_x=0, curr_y=0, dir=0, row_first=0, row_last=0, frame_last=0, busy=0, done=0, err=0.
REQ-035 The first start after rst deasserts is honoured.

Verification
REQ-036 Raster: max=8x6, border=3, pos_ready=1 -> exactly 2x... 
REQ-036 (corrected) Raster: max=10x8, border=3, pos_ready=1 -> sequence (3,3),(4,3),...,(6,3),(3,4),...,(6,4); frame_last at (6,4); done the cycle after; 8 positions total.
REQ-037 Serpentine: max=10x9, border=3 -> rows y=3 x3..6, y=4 x6..3 (dir=1), y=5 x3..6; 12 positions; frame_last at (6,5).
REQ-038 Backpressure: pos_ready toggled with random pattern, 50% duty -> outputs stable while stalled; the position sequence is identical to REQ-036.
REQ-039 Empty: max=6x20, border=3 -> err=1, done pulse at cycle 2, pos_valid stays 0; a following start with max=10x8 clears err.
REQ-040 Abort/reset: abort asserted at the 5th accept -> IDLE next cycle, no done. rst asserted mid-scan -> all outputs at reset values while rst is asserted.
REQ-041 Edge: max=7x7, border=3 (single pixel) -> one position (3,3) with row_first=row_last=frame_last=1.

Source files
------------

// File: rtl/pixel_scan_gen.sv
// pixel_scan_gen: walks the interior of a max_x by max_y image, skipping a
// border margin on every edge. Positions go out in raster or serpentine order
// over a valid/ready handshake, one per cycle while the consumer keeps up.
module pixel_scan_gen #(
    parameter int W  = 8,
    parameter int BW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  max_x,
    input  logic [W-1:0]  max_y,
    input  logic [BW-1:0] border,
    input  logic          serp,
    output logic          pos_valid,
    input  logic          pos_ready,
    output logic [W-1:0]  curr_x,
    output logic [W-1:0]  curr_y,
    output logic          dir,
    output logic          row_first,
    output logic          row_last,
    output logic          frame_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic [W:0]   ONE_WP = (W+1)'(1);
    localparam logic [W-1:0] ONE_W  = W'(1);

    state_t        state_q;
    logic          valid_q, dir_q, rf_q, rl_q, fl_q, busy_q, done_q, err_q, serp_q;
    logic [W-1:0]  curr_x_q, curr_y_q, xlo_q;
    logic [W:0]    xhi_q, yhi_q;

    // Bounds are evaluated one bit wider than the buses so a large border
    // against a small image cannot wrap into a bogus non-empty region.
    logic [W:0]    bdr_w, mx_w, my_w, xhi_w, yhi_w;
    logic          empty, rl_st, fl_st;

    logic [W-1:0]  x_nx, y_nx;
    logic          dir_nx, rf_nx, rl_nx, fl_nx;

    // Region bounds and first-position flags from the live inputs at start.
    always_comb begin
        bdr_w = (W+1)'(border);
        mx_w  = {1'b0, max_x};
        my_w  = {1'b0, max_y};
        xhi_w = mx_w - ONE_WP - bdr_w;
        yhi_w = my_w - ONE_WP - bdr_w;
        empty = (mx_w <= (bdr_w << 1)) || (my_w <= (bdr_w << 1));
        rl_st = (bdr_w == xhi_w);
        fl_st = rl_st && (bdr_w == yhi_w);
    end

    // Successor of the current position, plus its edge flags, so the flags
    // can be registered together with the coordinates.
    always_comb begin
        x_nx   = curr_x_q;
        y_nx   = curr_y_q;
        dir_nx = dir_q;
        if (!rl_q) begin
            x_nx = dir_q ? (curr_x_q - ONE_W) : (curr_x_q + ONE_W);
        end else begin
            y_nx = curr_y_q + ONE_W;
            if (serp_q) begin
                dir_nx = ~dir_q;
            end else begin
                x_nx   = xlo_q;
                dir_nx = 1'b0;
            end
        end
        rf_nx = dir_nx ? ({1'b0, x_nx} == xhi_q) : (x_nx == xlo_q);
        rl_nx = dir_nx ? (x_nx == xlo_q) : ({1'b0, x_nx} == xhi_q);
        fl_nx = rl_nx && ({1'b0, y_nx} == yhi_q);
    end

    // Scan FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            curr_x_q <= '0;
            curr_y_q <= '0;
            dir_q    <= 1'b0;
            rf_q     <= 1'b0;
            rl_q     <= 1'b0;
            fl_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            serp_q   <= 1'b0;
            xlo_q    <= '0;
            xhi_q    <= '0;
            yhi_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        serp_q <= serp;
                        xlo_q  <= W'(border);
                        xhi_q  <= xhi_w;
                        yhi_q  <= yhi_w;
                        err_q  <= empty;
                        if (empty) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_SCAN;
                            valid_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            curr_x_q <= W'(border);
                            curr_y_q <= W'(border);
                            dir_q    <= 1'b0;
                            rf_q     <= 1'b1;
                            rl_q     <= rl_st;
                            fl_q     <= fl_st;
                        end
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        rf_q    <= 1'b0;
                        rl_q    <= 1'b0;
                        fl_q    <= 1'b0;
                    end else if (valid_q && pos_ready) begin
                        if (fl_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            rf_q    <= 1'b0;
                            rl_q    <= 1'b0;
                            fl_q    <= 1'b0;
                        end else begin
                            curr_x_q <= x_nx;
                            curr_y_q <= y_nx;
                            dir_q    <= dir_nx;
                            rf_q     <= rf_nx;
                            rl_q     <= rl_nx;
                            fl_q     <= fl_nx;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pos_valid  = valid_q;
    assign curr_x     = curr_x_q;
    assign curr_y     = curr_y_q;
    assign dir        = dir_q;
    assign row_first  = rf_q;
    assign row_last   = rl_q;
    assign frame_last = fl_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Scoreboard bench for pixel_scan_gen: stimulus pushes the expected position
// stream, a negedge monitor compares whatever the DUT presents.
module tb_pixel_scan_gen;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic       serp = 1'b0, pos_ready = 1'b0;
    logic [7:0] max_x = '0, max_y = '0;
    logic [2:0] border = '0;
    logic       pos_valid, dir, row_first, row_last, frame_last, busy, done, err;
    logic [7:0] curr_x, curr_y;

    pixel_scan_gen #(.W(8), .BW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .max_x(max_x), .max_y(max_y), .border(border), .serp(serp),
        .pos_valid(pos_valid), .pos_ready(pos_ready),
        .curr_x(curr_x), .curr_y(curr_y), .dir(dir),
        .row_first(row_first), .row_last(row_last), .frame_last(frame_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, acc_cnt = 0;
    int fl_x = 0, fl_y = 0;
    logic [19:0] exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Expected stream: {x, y, dir, row_first, row_last, frame_last}.
    task automatic push_frame(input int mx, input int my, input int b, input int s);
        int n;
        n = mx - 2*b;
        for (int y = b; y <= my-1-b; y++) begin
            bit rev;
            rev = (s != 0) && (((y - b) % 2) == 1);
            for (int k = 0; k < n; k++) begin
                int x;
                x = rev ? (mx-1-b-k) : (b+k);
                exp_q.push_back({8'(x), 8'(y), rev, (k == 0), (k == n-1),
                                 (k == n-1) && (y == my-1-b)});
            end
        end
    endtask

    // Monitor: every presented position must match the queue head, stalled or not.
    always @(negedge clk) begin
        if (!rst && pos_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pos actual=(%0d,%0d) expected=none", curr_x, curr_y);
            end else begin
                chk("pos", int'({curr_x, curr_y, dir, row_first, row_last, frame_last}),
                    int'(exp_q[0]));
                if (pos_ready) begin
                    void'(exp_q.pop_front());
                    acc_cnt++;
                    if (frame_last) begin
                        fl_x = int'(curr_x);
                        fl_y = int'(curr_y);
                    end
                end
            end
        end
    end

    task automatic issue_start(input int mx, input int my, input int b, input int s);
        @(posedge clk); #1;
        max_x = 8'(mx); max_y = 8'(my); border = 3'(b); serp = s[0];
        start = 1'b1; pos_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scrambled inputs after start must have no effect on the running scan.
        max_x = 8'd3; max_y = 8'd2; border = 3'd0; serp = ~serp;
    endtask

    task automatic run_scan(input int mx, input int my, input int b, input int s,
                            input bit bp, input int exp_n, input int efx, input int efy,
                            input string nm);
        int a0, cyc;
        push_frame(mx, my, b, s);
        a0 = acc_cnt; fl_x = 0; fl_y = 0;
        issue_start(mx, my, b, s);
        chk({nm, "_valid_first"}, int'(pos_valid), 1);
        chk({nm, "_busy"}, int'(busy), 1);
        cyc = 0;
        while (!done && cyc < 3000) begin
            if (bp) pos_ready = 1'($urandom_range(0, 1));
            start = (cyc == 2);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; pos_ready = 1'b1;
        chk({nm, "_done_seen"}, int'(done), 1);
        if (!bp) chk({nm, "_cycles"}, cyc, exp_n);
        chk({nm, "_valid_after"}, int'(pos_valid), 0);
        chk({nm, "_busy_after"}, int'(busy), 0);
        chk({nm, "_count"}, acc_cnt - a0, exp_n);
        chk({nm, "_left"}, exp_q.size(), 0);
        chk({nm, "_fl_x"}, fl_x, efx);
        chk({nm, "_fl_y"}, fl_y, efy);
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, int'(done), 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int a0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(pos_valid), 0);
        chk("rst_xy", int'({curr_x, curr_y}), 0);
        chk("rst_flags", int'({dir, row_first, row_last, frame_last}), 0);
        chk("rst_status", int'({busy, done, err}), 0);
        rst = 1'b0;

        run_scan(10, 8, 3, 0, 1'b0, 8, 6, 4, "raster");
        run_scan(10, 9, 3, 1, 1'b0, 12, 6, 5, "serp");
        run_scan(10, 8, 3, 0, 1'b1, 8, 6, 4, "bp");

        issue_start(6, 20, 3, 0);
        chk("empty_done", int'(done), 1);
        chk("empty_err", int'(err), 1);
        chk("empty_valid", int'(pos_valid), 0);
        @(posedge clk); #1;
        chk("empty_done_pulse", int'(done), 0);
        chk("empty_err_sticky", int'(err), 1);
        chk("empty_valid2", int'(pos_valid), 0);
        run_scan(10, 8, 3, 0, 1'b0, 8, 6, 4, "after_empty");
        chk("err_cleared", int'(err), 0);

        push_frame(10, 8, 3, 0);
        a0 = acc_cnt;
        issue_start(10, 8, 3, 0);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", int'(pos_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_x", int'(curr_x), 3);
        chk("abort_y", int'(curr_y), 4);
        chk("abort_count", acc_cnt - a0, 5);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", int'(done), 0);
            @(posedge clk); #1;
        end
        exp_q.delete();

        push_frame(10, 8, 3, 0);
        issue_start(10, 8, 3, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("midrst_valid", int'(pos_valid), 0);
        chk("midrst_xy", int'({curr_x, curr_y}), 0);
        chk("midrst_flags", int'({dir, row_first, row_last, frame_last}), 0);
        chk("midrst_status", int'({busy, done, err}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();

        run_scan(7, 7, 3, 0, 1'b0, 1, 3, 3, "single");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
